mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between instruction fetch (IF) and data load/store (DM) requesters.
- Needed when the instruction and data memories are merged.
- Accepts one transaction at a time, issues it to memory and waits a fixed latency. Returns the read data or write acknowledge to the owner.
- DM has priority. A streak counter prevents fetch starvation.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width.
- MEM_LATENCY, 2, cycles from the mem_en cycle to the cycle mem_rdata is valid; legal range ≥1.
- MAX_DM_STREAK, 4, maximum consecutive DM grants while if_req is pending; legal range ≥1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request, level.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  one-cycle pulse: fetch request accepted.
- if_rvalid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  DATA_W  fetch read data.
- dm_req  in  1  data request, level.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  write data.
- dm_gnt  out  1  one-cycle pulse: data request accepted.
- dm_rvalid  out  1  one-cycle pulse: read data valid, or write acknowledge.
- dm_rdata  out  DATA_W  data read data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset:
  - Asynchronous; returns the FSM to IDLE with streak counter = 0 and latency counter = 0.
  - All outputs are registered and are 0 during reset and after it (data buses included).
  - An in-flight transaction is discarded; no rvalid is produced for it.
- States: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE:
  - Sampled at the rising edge. If any req is high, select an owner, latch its addr/we/wdata into the mem_* registers, and go to ISSUE.
  - A fetch always latches we = 0 and wdata = 0.
  - If no req is high, stay in IDLE.
- ISSUE (1 cycle):
  - mem_en = 1; the owner's gnt = 1.
  - Load latency counter with MEM_LATENCY and go to WAIT.
- WAIT:
  - mem_en = 0; mem_addr/mem_we/mem_wdata hold their values; counter decrements each cycle.
  - In the final WAIT cycle (counter = 1), capture mem_rdata into the owner's rdata register and go to RESP.
- RESP (1 cycle):
  - The owner's rvalid = 1 and its rdata is stable. The non-owner's rdata is unchanged.
  - A write also returns rvalid, with rdata = captured mem_rdata (don't-care content).
  - Go to IDLE.
- Timing:
  - A request first sampled in IDLE at cycle 0 gives gnt in cycle 1 and rvalid in cycle MEM_LATENCY+2.
  - The next arbitration is at cycle MEM_LATENCY+3, giving a period of MEM_LATENCY+3 cycles.
- Requester rules:
  - req and its addr/we/wdata must be stable from assertion until gnt is seen.
  - The requester drops req the cycle after gnt unless it is posting a new transaction.
  - req is ignored outside IDLE.
- Arbitration (IDLE with both requests pending):
  - DM wins unless streak = MAX_DM_STREAK, in which case IF wins.
- Streak counter:
  - DM grant while if_req = 1: streak += 1, saturating at MAX_DM_STREAK.
  - DM grant while if_req = 0: streak = 0.
  - Any IF grant: streak = 0.
- Single requester: that requester is granted regardless of streak.
- rdata registers hold their last value until overwritten.

Test Plan:
- Reset then idle: all outputs 0, busy 0.
- Mid-WAIT reset assertion: state → IDLE, no rvalid, outputs 0 asynchronously.
- IF read, MEM_LATENCY=2: if_req, if_addr=0x40 in cycle 0; memory model returns 0x00500093. Required: if_gnt and mem_en with mem_addr=0x40 in cycle 1; if_rvalid with if_rdata=0x00500093 in cycle 4; busy high cycles 1–4.
- DM write: dm_we=1, addr=0x100, wdata=0xDEADBEEF. Required: mem_we=1, mem_wdata=0xDEADBEEF with mem_en in cycle 1; dm_rvalid in cycle 4; a following DM read of 0x100 returns 0xDEADBEEF.
- Simultaneous if_req and dm_req from idle: DM is granted first. IF is granted at the next IDLE (cycle 5) if dm_req is dropped.
- Starvation guard, MAX_DM_STREAK=4: dm_req and if_req held continuously, with DM posting back-to-back requests. Required grant order: DM, DM, DM, DM, IF, DM….
- MEM_LATENCY=1 sweep: rvalid exactly 3 cycles after request sampling; rdata captured from the correct cycle (memory model changes mem_rdata every cycle).

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port unified memory between instruction fetch (IF) and data (DM).
// DM has priority; a streak counter bounds consecutive DM grants while a fetch waits.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W        = 64,
   parameter int unsigned DATA_W        = 64,
   parameter int unsigned MEM_LATENCY   = 2,
   parameter int unsigned MAX_DM_STREAK = 4
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,

   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_gnt,
   output logic              dm_rvalid,
   output logic [DATA_W-1:0] dm_rdata,

   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,

   output logic              busy
);

   localparam int unsigned CNT_W    = $clog2(MEM_LATENCY + 1);
   localparam int unsigned STREAK_W = $clog2(MAX_DM_STREAK + 1);
   localparam logic [CNT_W-1:0]    LAT_LOAD   = CNT_W'(MEM_LATENCY);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

   if (MEM_LATENCY < 1) begin : g_bad_latency
      $error("MEM_LATENCY must be at least 1");
   end
   if (MAX_DM_STREAK < 1) begin : g_bad_streak
      $error("MAX_DM_STREAK must be at least 1");
   end

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StResp
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    lat_cnt_q, lat_cnt_d;
   logic [STREAK_W-1:0] streak_q, streak_d;
   logic                owner_dm_q, owner_dm_d;

   logic                if_gnt_q, if_gnt_d;
   logic                dm_gnt_q, dm_gnt_d;
   logic                if_rvalid_q, if_rvalid_d;
   logic                dm_rvalid_q, dm_rvalid_d;
   logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
   logic                mem_en_q, mem_en_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                busy_q, busy_d;

   logic                grant_dm;

   // DM wins unless a waiting fetch has already been passed over MAX_DM_STREAK times.
   assign grant_dm = dm_req && !(if_req && (streak_q == STREAK_MAX));

   always_comb begin
      state_d     = state_q;
      lat_cnt_d   = lat_cnt_q;
      streak_d    = streak_q;
      owner_dm_d  = owner_dm_q;
      if_gnt_d    = 1'b0;
      dm_gnt_d    = 1'b0;
      if_rvalid_d = 1'b0;
      dm_rvalid_d = 1'b0;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      mem_en_d    = 1'b0;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      unique case (state_q)
         StIdle: begin
            if (dm_req || if_req) begin
               state_d    = StIssue;
               owner_dm_d = grant_dm;
               mem_en_d   = 1'b1;
               if (grant_dm) begin
                  dm_gnt_d    = 1'b1;
                  mem_we_d    = dm_we;
                  mem_addr_d  = dm_addr;
                  mem_wdata_d = dm_wdata;
                  if (!if_req) begin
                     streak_d = '0;
                  end else if (streak_q != STREAK_MAX) begin
                     streak_d = streak_q + STREAK_W'(1);
                  end
               end else begin
                  if_gnt_d    = 1'b1;
                  mem_we_d    = 1'b0;
                  mem_addr_d  = if_addr;
                  mem_wdata_d = '0;
                  streak_d    = '0;
               end
            end
         end

         StIssue: begin
            state_d   = StWait;
            lat_cnt_d = LAT_LOAD;
         end

         StWait: begin
            lat_cnt_d = lat_cnt_q - CNT_W'(1);
            // Last wait cycle: memory data is valid now.
            if (lat_cnt_q == CNT_W'(1)) begin
               state_d = StResp;
               if (owner_dm_q) begin
                  dm_rdata_d  = mem_rdata;
                  dm_rvalid_d = 1'b1;
               end else begin
                  if_rdata_d  = mem_rdata;
                  if_rvalid_d = 1'b1;
               end
            end
         end

         StResp: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         lat_cnt_q   <= '0;
         streak_q    <= '0;
         owner_dm_q  <= 1'b0;
         if_gnt_q    <= 1'b0;
         dm_gnt_q    <= 1'b0;
         if_rvalid_q <= 1'b0;
         dm_rvalid_q <= 1'b0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         lat_cnt_q   <= lat_cnt_d;
         streak_q    <= streak_d;
         owner_dm_q  <= owner_dm_d;
         if_gnt_q    <= if_gnt_d;
         dm_gnt_q    <= dm_gnt_d;
         if_rvalid_q <= if_rvalid_d;
         dm_rvalid_q <= dm_rvalid_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         busy_q      <= busy_d;
      end
   end

   assign if_gnt    = if_gnt_q;
   assign dm_gnt    = dm_gnt_q;
   assign if_rvalid = if_rvalid_q;
   assign dm_rvalid = dm_rvalid_q;
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;

endmodule
